riscv_pipeline_cpu: RTL and testbench

//   Top-level 5-stage in-order RV32 subset CPU: IF, ID, EX, MEM, WB.
//   - Internal word instruction memory and data memory; 32x32 register file.
//   - Forwarding unit, load-use hazard unit, branch resolution in ID with IF flush.
//   - Memory arrays are loaded and inspected hierarchically by the bench.

---
 rtl/riscv_pipeline_cpu.sv | 250 +++++++++++++++++++++++++
 tb/tb_riscv_pipeline_cpu.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipeline_cpu.sv
// Five-stage in-order RV32 subset core (IF/ID/EX/MEM/WB) with EX forwarding,
// load-use interlock and beq resolved in ID. Memories are preloaded by the environment.
module riscv_pipeline_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [31:0] pc_o,
    output logic        stall_o,
    output logic        flush_o
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_MUL, ALU_SRA
    } alu_op_e;

    logic [31:0] r_imem [IMEM_WORDS];
    logic [31:0] r_dmem [DMEM_WORDS];
    logic [31:0] r_rf   [32];

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr, r_ifid_pc;

    logic        r_idex_regwrite, r_idex_memread, r_idex_memwrite, r_idex_use_imm;
    alu_op_e     r_idex_alu;
    logic [4:0]  r_idex_rs1, r_idex_rs2, r_idex_rd;
    logic [31:0] r_idex_rd1, r_idex_rd2, r_idex_imm;

    logic        r_exmem_regwrite, r_exmem_memread, r_exmem_memwrite;
    logic [4:0]  r_exmem_rd;
    logic [31:0] r_exmem_alu, r_exmem_sdata;

    logic        r_memwb_regwrite;
    logic [4:0]  r_memwb_rd;
    logic [31:0] r_memwb_data;

    // ---------------- ID decode ----------------
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm;
    logic        w_regwrite, w_memread, w_memwrite, w_use_imm, w_use_rs2, w_is_beq;
    alu_op_e     w_alu;

    assign w_op    = r_ifid_instr[6:0];
    assign w_rd    = r_ifid_instr[11:7];
    assign w_f3    = r_ifid_instr[14:12];
    assign w_rs1   = r_ifid_instr[19:15];
    assign w_rs2   = r_ifid_instr[24:20];
    assign w_f7    = r_ifid_instr[31:25];
    assign w_imm_i = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
    assign w_imm_s = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
    assign w_imm_b = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                      r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};

    always_comb begin
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_use_imm  = 1'b0;
        w_use_rs2  = 1'b0;
        w_is_beq   = 1'b0;
        w_alu      = ALU_ADD;
        w_imm      = w_imm_i;
        case (w_op)
            7'b0110011: begin
                w_use_rs2  = 1'b1;
                w_regwrite = 1'b1;
                case ({w_f7, w_f3})
                    10'b0000000_111: w_alu = ALU_AND;
                    10'b0000000_100: w_alu = ALU_XOR;
                    10'b0000000_001: w_alu = ALU_SLL;
                    10'b0000000_000: w_alu = ALU_ADD;
                    10'b0100000_000: w_alu = ALU_SUB;
                    10'b0000001_000: w_alu = ALU_MUL;
                    default:         w_regwrite = 1'b0;
                endcase
            end
            7'b0010011: begin
                if (w_f3 == 3'b000) begin
                    w_regwrite = 1'b1;
                    w_use_imm  = 1'b1;
                end else if (w_f3 == 3'b101 && w_f7 == 7'b0100000) begin
                    w_regwrite = 1'b1;
                    w_use_imm  = 1'b1;
                    w_alu      = ALU_SRA;
                end
            end
            7'b0000011: begin
                if (w_f3 == 3'b010) begin
                    w_regwrite = 1'b1;
                    w_memread  = 1'b1;
                    w_use_imm  = 1'b1;
                end
            end
            7'b0100011: begin
                w_use_rs2 = 1'b1;
                if (w_f3 == 3'b010) begin
                    w_memwrite = 1'b1;
                    w_use_imm  = 1'b1;
                    w_imm      = w_imm_s;
                end
            end
            7'b1100011: begin
                w_use_rs2 = 1'b1;
                w_is_beq  = (w_f3 == 3'b000);
            end
            default: ;
        endcase
    end

    // Register read sees a same-cycle WB write (write-before-read)
    logic [31:0] w_rd1, w_rd2;
    assign w_rd1 = (w_rs1 == 5'd0) ? 32'd0 :
                   (r_memwb_regwrite && r_memwb_rd == w_rs1) ? r_memwb_data : r_rf[w_rs1];
    assign w_rd2 = (w_rs2 == 5'd0) ? 32'd0 :
                   (r_memwb_regwrite && r_memwb_rd == w_rs2) ? r_memwb_data : r_rf[w_rs2];

    logic w_loaduse, w_stall, w_flush;
    assign w_loaduse = r_idex_memread && (r_idex_rd != 5'd0) &&
                       ((r_idex_rd == w_rs1) || (w_use_rs2 && r_idex_rd == w_rs2));
    // beq is never interlocked; software spaces its operands
    assign w_stall   = w_loaduse && !w_is_beq;
    assign w_flush   = w_is_beq && (w_rd1 == w_rd2) && !w_stall;

    assign pc_o    = r_pc;
    assign stall_o = w_stall;
    assign flush_o = w_flush;

    // ---------------- IF / IF-ID ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc         <= 32'd0;
            r_ifid_instr <= 32'd0;
            r_ifid_pc    <= 32'd0;
        end else if (!w_stall) begin
            if (w_flush)
                r_pc <= r_ifid_pc + w_imm_b;
            else if (start_i)
                r_pc <= r_pc + 32'd4;
            if (w_flush || !start_i) begin
                r_ifid_instr <= 32'd0;
                r_ifid_pc    <= 32'd0;
            end else begin
                r_ifid_instr <= r_imem[r_pc[IW+1:2]];
                r_ifid_pc    <= r_pc;
            end
        end
    end

    // ---------------- ID-EX ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i || w_stall) begin
            r_idex_regwrite <= 1'b0;
            r_idex_memread  <= 1'b0;
            r_idex_memwrite <= 1'b0;
            r_idex_use_imm  <= 1'b0;
            r_idex_alu      <= ALU_ADD;
            r_idex_rs1      <= 5'd0;
            r_idex_rs2      <= 5'd0;
            r_idex_rd       <= 5'd0;
            r_idex_rd1      <= 32'd0;
            r_idex_rd2      <= 32'd0;
            r_idex_imm      <= 32'd0;
        end else begin
            r_idex_regwrite <= w_regwrite;
            r_idex_memread  <= w_memread;
            r_idex_memwrite <= w_memwrite;
            r_idex_use_imm  <= w_use_imm;
            r_idex_alu      <= w_alu;
            r_idex_rs1      <= w_rs1;
            r_idex_rs2      <= w_rs2;
            r_idex_rd       <= w_regwrite ? w_rd : 5'd0;
            r_idex_rd1      <= w_rd1;
            r_idex_rd2      <= w_rd2;
            r_idex_imm      <= w_imm;
        end
    end

    // ---------------- EX ----------------
    logic [31:0] w_fwd_a, w_fwd_b, w_opb, w_alu_y;
    assign w_fwd_a = (r_exmem_regwrite && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs1) ? r_exmem_alu :
                     (r_memwb_regwrite && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs1) ? r_memwb_data :
                     r_idex_rd1;
    assign w_fwd_b = (r_exmem_regwrite && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs2) ? r_exmem_alu :
                     (r_memwb_regwrite && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs2) ? r_memwb_data :
                     r_idex_rd2;
    assign w_opb   = r_idex_use_imm ? r_idex_imm : w_fwd_b;

    always_comb begin
        w_alu_y = w_fwd_a + w_opb;
        case (r_idex_alu)
            ALU_SUB: w_alu_y = w_fwd_a - w_opb;
            ALU_AND: w_alu_y = w_fwd_a & w_opb;
            ALU_XOR: w_alu_y = w_fwd_a ^ w_opb;
            ALU_SLL: w_alu_y = w_fwd_a << w_opb[4:0];
            ALU_MUL: w_alu_y = w_fwd_a * w_opb;
            ALU_SRA: w_alu_y = $unsigned($signed(w_fwd_a) >>> w_opb[4:0]);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_exmem_regwrite <= 1'b0;
            r_exmem_memread  <= 1'b0;
            r_exmem_memwrite <= 1'b0;
            r_exmem_rd       <= 5'd0;
            r_exmem_alu      <= 32'd0;
            r_exmem_sdata    <= 32'd0;
        end else begin
            r_exmem_regwrite <= r_idex_regwrite;
            r_exmem_memread  <= r_idex_memread;
            r_exmem_memwrite <= r_idex_memwrite;
            r_exmem_rd       <= r_idex_rd;
            r_exmem_alu      <= w_alu_y;
            r_exmem_sdata    <= w_fwd_b;
        end
    end

    // ---------------- MEM / WB ----------------
    logic [31:0] w_dmem_rdata;
    assign w_dmem_rdata = r_dmem[r_exmem_alu[DW+1:2]];

    always_ff @(posedge clk_i) begin
        if (r_exmem_memwrite)
            r_dmem[r_exmem_alu[DW+1:2]] <= r_exmem_sdata;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_memwb_regwrite <= 1'b0;
            r_memwb_rd       <= 5'd0;
            r_memwb_data     <= 32'd0;
        end else begin
            r_memwb_regwrite <= r_exmem_regwrite;
            r_memwb_rd       <= r_exmem_rd;
            r_memwb_data     <= r_exmem_memread ? w_dmem_rdata : r_exmem_alu;
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_memwb_regwrite && r_memwb_rd != 5'd0)
            r_rf[r_memwb_rd] <= r_memwb_data;
    end
endmodule

// File: tb/tb_riscv_pipeline_cpu.sv
// Scoreboarded bench: an ISA-level interpreter predicts the ordered register writes,
// stall/flush counts and final memory image; a monitor checks every writeback.
module tb_riscv_pipeline_cpu;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] pc;
    logic        stall, flush;

    riscv_pipeline_cpu dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .pc_o(pc), .stall_o(stall), .flush_o(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] rd; logic [31:0] val; } wr_t;

    int n_vec = 0, n_err = 0;
    int cnt_stall, cnt_flush, popped;
    int m_stalls, m_flushes;
    wr_t exp_q[$];
    wr_t wlog[$];
    logic [31:0] prog[$];
    logic [31:0] i_rf[32], i_dm[32], m_rf[32], m_dm[32];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endfunction

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] off, logic [4:0] rs2, logic [4:0] rs1);
        return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_instr(bit alu_only);
        int k;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] im;
        k   = alu_only ? $urandom_range(0, 7) : $urandom_range(0, 9);
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        im  = 12'($urandom_range(0, 255)) - 12'd128;
        case (k)
            0: return enc_r(7'h00, rs2, rs1, 3'd0, rd);
            1: return enc_r(7'h20, rs2, rs1, 3'd0, rd);
            2: return enc_r(7'h00, rs2, rs1, 3'd7, rd);
            3: return enc_r(7'h00, rs2, rs1, 3'd4, rd);
            4: return enc_r(7'h00, rs2, rs1, 3'd1, rd);
            5: return enc_r(7'h01, rs2, rs1, 3'd0, rd);
            6: return enc_i(im, rs1, 3'd0, rd, 7'b0010011);
            7: return enc_i({7'b0100000, im[4:0]}, rs1, 3'd5, rd, 7'b0010011);
            8: return enc_i(im, rs1, 3'd2, rd, 7'b0000011);
            default: return enc_s(im, rs2, rs1);
        endcase
    endfunction

    task automatic gen_prog(int len);
        prog.delete();
        while (prog.size() < len) begin
            if ($urandom_range(0, 7) == 0) begin
                int k;
                logic [4:0] a, b;
                k = $urandom_range(1, 2);
                a = 5'($urandom_range(0, 7));
                b = $urandom_range(0, 1) ? a : 5'($urandom_range(0, 7));
                prog.push_back(32'd0);
                prog.push_back(32'd0);
                prog.push_back(enc_b(13'(4 * (k + 1)), b, a));
                for (int j = 0; j < k; j++) prog.push_back(rand_instr(1'b0));
            end else begin
                prog.push_back(rand_instr(1'b0));
            end
        end
    endtask

    task automatic rand_state();
        for (int i = 0; i < 32; i++) begin
            i_rf[i] = $urandom;
            i_dm[i] = $urandom;
        end
        i_rf[0] = 32'd0;
    endtask

    // ---------------- ISA reference model ----------------
    function automatic void m_wr(logic [4:0] rd, logic [31:0] v);
        if (rd != 5'd0) begin
            m_rf[rd] = v;
            exp_q.push_back('{rd, v});
            wlog.push_back('{rd, v});
        end
    endfunction

    task automatic model();
        int pc_m = 0, steps = 0;
        logic [4:0] plw = 5'd0;
        m_rf = i_rf;
        m_dm = i_dm;
        m_stalls = 0;
        m_flushes = 0;
        while (pc_m / 4 < prog.size() && steps < 2000) begin
            logic [31:0] ins, a, b, immi, imms, immb, npc, addr;
            logic signed [31:0] sa;
            logic [6:0] op, f7;
            logic [2:0] f3;
            logic [4:0] rd, rs1, rs2;
            bit is_beq, uses2;
            ins  = prog[pc_m / 4];
            op   = ins[6:0];  rd = ins[11:7]; f3 = ins[14:12];
            rs1  = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
            immi = {{20{ins[31]}}, ins[31:20]};
            imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            is_beq = (op == 7'h63) && (f3 == 3'd0);
            uses2  = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
            if (plw != 5'd0 && !is_beq && (rs1 == plw || (uses2 && rs2 == plw))) m_stalls++;
            plw = (op == 7'h03 && f3 == 3'd2) ? rd : 5'd0;
            a = m_rf[rs1];
            b = m_rf[rs2];
            sa = a;
            npc = pc_m + 4;
            case (op)
                7'h33: case ({f7, f3})
                    {7'h00, 3'd7}: m_wr(rd, a & b);
                    {7'h00, 3'd4}: m_wr(rd, a ^ b);
                    {7'h00, 3'd1}: m_wr(rd, a << b[4:0]);
                    {7'h00, 3'd0}: m_wr(rd, a + b);
                    {7'h20, 3'd0}: m_wr(rd, a - b);
                    {7'h01, 3'd0}: m_wr(rd, a * b);
                    default: ;
                endcase
                7'h13: begin
                    if (f3 == 3'd0) m_wr(rd, a + immi);
                    else if (f3 == 3'd5 && f7 == 7'h20) m_wr(rd, 32'(sa >>> immi[4:0]));
                end
                7'h03: if (f3 == 3'd2) begin
                    addr = a + immi;
                    m_wr(rd, m_dm[addr[6:2]]);
                end
                7'h23: if (f3 == 3'd2) begin
                    addr = a + imms;
                    m_dm[addr[6:2]] = b;
                end
                7'h63: if (is_beq && a == b) begin
                    m_flushes++;
                    npc = pc_m + immb;
                end
                default: ;
            endcase
            pc_m = int'(npc);
            steps++;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall) cnt_stall++;
            if (flush) cnt_flush++;
            if (dut.r_memwb_regwrite && dut.r_memwb_rd != 5'd0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wb_unexpected: got write x%0d=%h, want none",
                             dut.r_memwb_rd, dut.r_memwb_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wb_rd", 32'(dut.r_memwb_rd), 32'(e.rd));
                    chk("wb_val", dut.r_memwb_data, e.val);
                    popped++;
                end
            end
        end
    end

    // ---------------- sequencing ----------------
    task automatic prep();
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) dut.r_imem[i] = 32'd0;
        foreach (prog[i]) dut.r_imem[i] = prog[i];
        for (int i = 0; i < 32; i++) begin
            dut.r_rf[i]   = i_rf[i];
            dut.r_dmem[i] = i_dm[i];
        end
        exp_q.delete();
        wlog.delete();
        model();
        cnt_stall = 0;
        cnt_flush = 0;
        popped = 0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(int n);
        start = 1'b1;
        repeat (n) @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic final_checks(string tag);
        chk({tag, "_sb_drain"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_stalls"}, 32'(cnt_stall), 32'(m_stalls));
        chk({tag, "_flushes"}, 32'(cnt_flush), 32'(m_flushes));
        for (int i = 1; i < 32; i++) chk($sformatf("%s_x%0d", tag, i), dut.r_rf[i], m_rf[i]);
        for (int i = 0; i < 32; i++) chk($sformatf("%s_dmem%0d", tag, i), dut.r_dmem[i], m_dm[i]);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);

        // start gating, then forwarding chain
        rand_state();
        prog = '{enc_i(12'd3, 5'd0, 3'd0, 5'd1, 7'b0010011),
                 enc_i(12'd4, 5'd1, 3'd0, 5'd2, 7'b0010011),
                 enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3)};
        prep();
        release_rst();
        repeat (3) begin
            @(negedge clk);
            chk("hold_pc", pc, 32'd0);
        end
        for (int i = 1; i < 4; i++) chk($sformatf("hold_x%0d", i), dut.r_rf[i], i_rf[i]);
        start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("pc_seq%0d", i), pc, 32'(4 * i));
        end
        run(10);
        final_checks("fwd");
        chk("fwd_x3_const", dut.r_rf[3], 32'd10);

        // load-use
        rand_state();
        i_dm[0] = 32'd5;
        prog = '{enc_i(12'd0, 5'd0, 3'd2, 5'd1, 7'b0000011),
                 enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2)};
        prep();
        release_rst();
        run(10);
        final_checks("lu");
        chk("lu_x2_const", dut.r_rf[2], 32'd10);

        // taken beq flushes its delay slot
        rand_state();
        i_rf[5] = 32'd0;
        prog = '{enc_b(13'd8, 5'd0, 5'd0),
                 enc_i(12'd1, 5'd0, 3'd0, 5'd5, 7'b0010011),
                 enc_i(12'd9, 5'd0, 3'd0, 5'd6, 7'b0010011)};
        prep();
        release_rst();
        start = 1'b1;
        @(negedge clk);
        chk("br_pc1", pc, 32'd4);
        chk("br_flush1", 32'(flush), 32'd1);
        @(negedge clk);
        chk("br_pc2", pc, 32'd8);
        chk("br_flush2", 32'(flush), 32'd0);
        run(10);
        final_checks("br");
        chk("br_x5_const", dut.r_rf[5], 32'd0);

        // store and arithmetic shift
        rand_state();
        prog = '{enc_i(12'hFF9, 5'd0, 3'd0, 5'd2, 7'b0010011),
                 enc_s(12'd4, 5'd2, 5'd0),
                 enc_i({7'b0100000, 5'd1}, 5'd2, 3'd5, 5'd4, 7'b0010011)};
        prep();
        release_rst();
        run(10);
        final_checks("st");
        chk("st_dmem1_const", dut.r_dmem[1], 32'hFFFF_FFF9);
        chk("st_x4_const", dut.r_rf[4], 32'hFFFF_FFFC);

        // randomized programs
        for (int t = 0; t < 8; t++) begin
            rand_state();
            gen_prog(40);
            prep();
            release_rst();
            run(2 * prog.size() + 20);
            final_checks($sformatf("rnd%0d", t));
        end

        // asynchronous reset mid-program
        rand_state();
        prog.delete();
        for (int i = 0; i < 12; i++) prog.push_back(rand_instr(1'b1));
        prep();
        release_rst();
        start = 1'b1;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_pc_hold", pc, 32'd0);
        m_rf = i_rf;
        for (int i = 0; i < popped; i++) m_rf[wlog[i].rd] = wlog[i].val;
        for (int i = 1; i < 32; i++) chk($sformatf("arst_x%0d", i), dut.r_rf[i], m_rf[i]);
        for (int i = 0; i < 32; i++) chk($sformatf("arst_dmem%0d", i), dut.r_dmem[i], i_dm[i]);
        exp_q.delete();
        release_rst();
        repeat (6) @(negedge clk);
        chk("arst_idle_pc", pc, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
